if_fetch: RTL and testbench

IF_FETCH -- requirements
Module: if_fetch

---
 rtl/if_fetch_pkg.sv | 23 ++
 rtl/fetch_skid.sv | 29 ++
 rtl/if_fetch.sv | 156 +++++++++++++++
 tb/tb_if_fetch.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/if_fetch_pkg.sv
// Shared fetch definitions: next-PC select codes, fetch FSM states
// and the default reset vector.
package if_fetch_pkg;

    localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;

    typedef enum logic [1:0] {
        SPC_NPC = 2'b00,
        SPC_JR  = 2'b01,
        SPC_PC4 = 2'b10
    } spc_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10
    } fetch_state_e;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry skid buffer holding a fetch response that arrived
// while decode was stalled.
module fetch_skid (
    input  logic        clk,
    input  logic        reset,
    input  logic        push,
    input  logic        pop,
    input  logic [31:0] data_in,
    input  logic [31:0] pc4_in,
    output logic        valid,
    output logic [31:0] data,
    output logic [31:0] pc4
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= 32'h0;
            pc4   <= 32'h0;
        end else if (push) begin
            valid <= 1'b1;
            data  <= data_in;
            pc4   <= pc4_in;
        end else if (pop) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: one-outstanding request/grant/rvalid
// fetch FSM feeding the IF/ID register.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  S_PC,
    input  logic [31:0] npc_target,
    input  logic [31:0] jr_target,
    input  logic        IF_ID_flush,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] IR_D,
    output logic [31:0] PC4_D,
    output logic        valid_D
);

    fetch_state_e state, state_nxt;

    logic [31:0] pc, pc_nxt;
    logic [31:0] fetch_pc, fetch_pc4;
    logic [31:0] pend_pc, pend_pc_nxt;
    logic        pend_valid, pend_valid_nxt;
    logic        kill, kill_nxt;
    logic        redir;
    logic [31:0] target;
    logic        rsp_take;
    logic        skid_push, skid_pop, skid_valid;
    logic [31:0] skid_data, skid_pc4;

    // A full skid buffer holds off new requests.
    assign imem_req  = (state == ST_REQ) && !skid_valid;
    assign imem_addr = pc;
    assign fetch_pc4 = fetch_pc + 32'd4;

    assign redir = valid_D && !stall &&
                   (S_PC == SPC_NPC || S_PC == SPC_JR);
    assign target = word_align(
        (S_PC == SPC_JR) ? jr_target : npc_target);

    assign rsp_take = (state == ST_WAIT) && imem_rvalid &&
                      !kill && !IF_ID_flush;
    assign skid_push = rsp_take && stall;
    assign skid_pop  = skid_valid && (!stall || IF_ID_flush);

    fetch_skid u_skid (
        .clk     (clk),
        .reset   (reset),
        .push    (skid_push),
        .pop     (skid_pop),
        .data_in (imem_rdata),
        .pc4_in  (fetch_pc4),
        .valid   (skid_valid),
        .data    (skid_data),
        .pc4     (skid_pc4)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: state_nxt = ST_REQ;
            ST_REQ: begin
                if (imem_req && imem_gnt)
                    state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem_rvalid)
                    state_nxt = ST_REQ;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // A redirect goes straight to pc unless a request is on the
    // bus, where the address must stay put; then it parks.
    always_comb begin
        pc_nxt         = pc;
        pend_pc_nxt    = pend_pc;
        pend_valid_nxt = pend_valid;
        if (redir && !imem_req) begin
            pc_nxt         = target;
            pend_valid_nxt = 1'b0;
        end else begin
            if (redir) begin
                pend_pc_nxt    = target;
                pend_valid_nxt = 1'b1;
            end
            if (imem_req && imem_gnt) begin
                pc_nxt = pc + 32'd4;
            end else if (pend_valid && !imem_req) begin
                pc_nxt         = pend_pc;
                pend_valid_nxt = 1'b0;
            end
        end
    end

    always_comb begin
        kill_nxt = kill;
        if (IF_ID_flush &&
            (imem_req || (state == ST_WAIT && !imem_rvalid)))
            kill_nxt = 1'b1;
        else if (state == ST_WAIT && imem_rvalid)
            kill_nxt = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= ST_IDLE;
            pc         <= RESET_PC;
            fetch_pc   <= RESET_PC;
            pend_pc    <= 32'h0;
            pend_valid <= 1'b0;
            kill       <= 1'b0;
        end else begin
            state      <= state_nxt;
            pc         <= pc_nxt;
            pend_pc    <= pend_pc_nxt;
            pend_valid <= pend_valid_nxt;
            kill       <= kill_nxt;
            if (imem_req && imem_gnt)
                fetch_pc <= pc;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IR_D    <= 32'h0;
            PC4_D   <= 32'h0;
            valid_D <= 1'b0;
        end else if (!stall) begin
            if (IF_ID_flush) begin
                IR_D    <= 32'h0;
                valid_D <= 1'b0;
            end else if (rsp_take) begin
                IR_D    <= imem_rdata;
                PC4_D   <= fetch_pc4;
                valid_D <= 1'b1;
            end else if (skid_valid) begin
                IR_D    <= skid_data;
                PC4_D   <= skid_pc4;
                valid_D <= 1'b1;
            end else begin
                IR_D    <= 32'h0;
                valid_D <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Directed per-cycle vector bench for if_fetch plus a hand-written
// reset-during-WAIT sequence.
module tb_if_fetch;

    logic        clk;
    logic        reset;
    logic [1:0]  S_PC;
    logic [31:0] npc_target;
    logic [31:0] jr_target;
    logic        IF_ID_flush;
    logic        stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] IR_D;
    logic [31:0] PC4_D;
    logic        valid_D;

    int n_chk;
    int n_fail;

    typedef struct {
        logic [1:0]  s;
        logic [31:0] n;
        logic [31:0] j;
        logic        f;
        logic        st;
        logic        g;
        logic        r;
        logic [31:0] d;
        logic        rq;
        logic [31:0] a;
        logic [31:0] ir;
        logic [31:0] p4;
        logic        v;
    } vec_t;

    vec_t vecs[$];

    if_fetch dut (
        .clk         (clk),
        .reset       (reset),
        .S_PC        (S_PC),
        .npc_target  (npc_target),
        .jr_target   (jr_target),
        .IF_ID_flush (IF_ID_flush),
        .stall       (stall),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .IR_D        (IR_D),
        .PC4_D       (PC4_D),
        .valid_D     (valid_D)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] s,
                         input logic [31:0] n, j,
                         input logic f, st, g, r,
                         input logic [31:0] d);
        S_PC        = s;
        npc_target  = n;
        jr_target   = j;
        IF_ID_flush = f;
        stall       = st;
        imem_gnt    = g;
        imem_rvalid = r;
        imem_rdata  = d;
    endtask

    task automatic add(input logic [1:0] s,
                       input logic [31:0] n, j,
                       input logic f, st, g, r,
                       input logic [31:0] d,
                       input logic rq,
                       input logic [31:0] a, ir, p4,
                       input logic v);
        vec_t e;
        e = '{s, n, j, f, st, g, r, d, rq, a, ir, p4, v};
        vecs.push_back(e);
    endtask

    task automatic chk_out(input string tag,
                           input logic rq,
                           input logic [31:0] a, ir, p4,
                           input logic v);
        chk({tag, " imem_req"}, {31'h0, imem_req}, {31'h0, rq});
        chk({tag, " imem_addr"}, imem_addr, a);
        chk({tag, " IR_D"}, IR_D, ir);
        chk({tag, " PC4_D"}, PC4_D, p4);
        chk({tag, " valid_D"}, {31'h0, valid_D}, {31'h0, v});
    endtask

    localparam logic [31:0] Z = 32'h0;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        drive(2'b10, Z, Z, 0, 0, 0, 0, Z);

        // sequential fetch
        add(2'b10, Z, Z, 0, 0, 0, 0, Z, 0, 32'h3000, Z, Z, 0);
        add(2'b10, Z, Z, 0, 0, 1, 0, Z, 1, 32'h3000, Z, Z, 0);
        add(2'b10, Z, Z, 0, 0, 0, 1, 32'hA000_3000,
            0, 32'h3004, Z, Z, 0);
        add(2'b10, Z, Z, 0, 0, 1, 0, Z,
            1, 32'h3004, 32'hA000_3000, 32'h3004, 1);
        add(2'b10, Z, Z, 0, 0, 0, 1, 32'hA000_3004,
            0, 32'h3008, Z, 32'h3004, 0);
        // taken branch with flush, 0x3008 response killed
        add(2'b00, 32'h3040, 32'h5550, 1, 0, 1, 0, Z,
            1, 32'h3008, 32'hA000_3004, 32'h3008, 1);
        add(2'b10, Z, Z, 0, 0, 0, 1, 32'hA000_3008,
            0, 32'h300C, Z, 32'h3008, 0);
        add(2'b10, Z, Z, 0, 0, 1, 0, Z, 1, 32'h3040, Z, 32'h3008, 0);
        add(2'b10, Z, Z, 0, 0, 0, 1, 32'hA000_3040,
            0, 32'h3044, Z, 32'h3008, 0);
        // JR
        add(2'b01, 32'h6660, 32'h3100, 1, 0, 1, 0, Z,
            1, 32'h3044, 32'hA000_3040, 32'h3044, 1);
        add(2'b10, Z, Z, 0, 0, 0, 1, 32'hA000_3044,
            0, 32'h3048, Z, 32'h3044, 0);
        // grant backpressure
        for (int k = 0; k < 4; k++)
            add(2'b10, Z, Z, 0, 0, 0, 0, Z,
                1, 32'h3100, Z, 32'h3044, 0);
        add(2'b10, Z, Z, 0, 0, 1, 0, Z, 1, 32'h3100, Z, 32'h3044, 0);
        add(2'b10, Z, Z, 0, 0, 0, 1, 32'hA000_3100,
            0, 32'h3104, Z, 32'h3044, 0);
        // stall with response in flight, skid replay
        add(2'b10, Z, Z, 0, 1, 1, 0, Z,
            1, 32'h3104, 32'hA000_3100, 32'h3104, 1);
        add(2'b10, Z, Z, 0, 1, 0, 1, 32'hA000_3104,
            0, 32'h3108, 32'hA000_3100, 32'h3104, 1);
        add(2'b10, Z, Z, 0, 1, 0, 0, Z,
            0, 32'h3108, 32'hA000_3100, 32'h3104, 1);
        add(2'b10, Z, Z, 0, 1, 0, 0, Z,
            0, 32'h3108, 32'hA000_3100, 32'h3104, 1);
        add(2'b10, Z, Z, 0, 0, 0, 0, Z,
            0, 32'h3108, 32'hA000_3100, 32'h3104, 1);
        add(2'b10, Z, Z, 0, 0, 0, 0, Z,
            1, 32'h3108, 32'hA000_3104, 32'h3108, 1);
        add(2'b10, Z, Z, 0, 0, 1, 0, Z, 1, 32'h3108, Z, 32'h3108, 0);
        // flush over stall empties the skid
        add(2'b10, Z, Z, 0, 1, 0, 1, 32'hA000_3108,
            0, 32'h310C, Z, 32'h3108, 0);
        add(2'b10, Z, Z, 1, 1, 0, 0, Z, 0, 32'h310C, Z, 32'h3108, 0);
        add(2'b10, Z, Z, 0, 0, 0, 0, Z, 1, 32'h310C, Z, 32'h3108, 0);
        add(2'b10, Z, Z, 0, 0, 1, 0, Z, 1, 32'h310C, Z, 32'h3108, 0);
        add(2'b10, Z, Z, 0, 0, 0, 1, 32'hA000_310C,
            0, 32'h3110, Z, 32'h3108, 0);
        // parked redirect to the top of memory, +4 wraps
        add(2'b00, 32'hFFFF_FFFC, Z, 0, 0, 0, 0, Z,
            1, 32'h3110, 32'hA000_310C, 32'h3110, 1);
        add(2'b10, Z, Z, 0, 0, 1, 0, Z, 1, 32'h3110, Z, 32'h3110, 0);
        add(2'b10, Z, Z, 0, 0, 0, 1, 32'hA000_3110,
            0, 32'h3114, Z, 32'h3110, 0);
        add(2'b10, Z, Z, 0, 0, 1, 0, Z,
            1, 32'hFFFF_FFFC, 32'hA000_3110, 32'h3114, 1);
        add(2'b10, Z, Z, 0, 0, 0, 1, 32'h1234_5678,
            0, Z, Z, 32'h3114, 0);
        // S_PC=11 behaves as PC+4
        add(2'b11, 32'h7770, 32'h8880, 0, 0, 0, 0, Z,
            1, Z, 32'h1234_5678, Z, 1);
        add(2'b10, Z, Z, 0, 0, 0, 0, Z, 1, Z, Z, Z, 0);

        repeat (2) @(negedge clk);
        #1;
        chk_out("reset", 0, 32'h3000, Z, Z, 0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            drive(vecs[i].s, vecs[i].n, vecs[i].j, vecs[i].f,
                  vecs[i].st, vecs[i].g, vecs[i].r, vecs[i].d);
            #1;
            chk_out($sformatf("row%0d", i), vecs[i].rq, vecs[i].a,
                    vecs[i].ir, vecs[i].p4, vecs[i].v);
            @(negedge clk);
        end

        // reset asserted while a fetch is in WAIT
        drive(2'b10, Z, Z, 0, 0, 1, 0, Z);
        #1;
        chk("h1 imem_req", {31'h0, imem_req}, 32'h1);
        chk("h1 imem_addr", imem_addr, Z);
        @(negedge clk);
        drive(2'b10, Z, Z, 0, 0, 0, 1, 32'hDEAD_BEEF);
        #1;
        chk("h2 imem_addr", imem_addr, 32'h4);
        @(negedge clk);
        drive(2'b10, Z, Z, 0, 1, 1, 0, Z);
        #1;
        chk_out("h3", 1, 32'h4, 32'hDEAD_BEEF, 32'h4, 1);
        @(negedge clk);
        drive(2'b10, Z, Z, 0, 1, 0, 0, Z);
        #1;
        chk_out("h4", 0, 32'h8, 32'hDEAD_BEEF, 32'h4, 1);
        #2;
        reset = 1'b0;
        #1;
        chk_out("async_rst", 0, 32'h3000, Z, Z, 0);
        @(negedge clk);
        reset = 1'b1;
        drive(2'b10, Z, Z, 0, 0, 1, 0, Z);
        #1;
        chk_out("rel_idle", 0, 32'h3000, Z, Z, 0);
        @(negedge clk);
        #1;
        chk_out("rel_req", 1, 32'h3000, Z, Z, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
